// File: rtl/mmix_ldst_queue.sv
// MMIX load/store queue: buffers tagged memory requests in a circular FIFO,
// issues them one at a time to the memory port, and returns one registered
// response per request in acceptance order. Loads are zero/sign-extended by
// size. Signed stores flag a value that does not fit the store width.
module mmix_ldst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic              flush,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_datasize,
  output logic [63:0]       mem_writedata,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [63:0]       rsp_data,
  output logic              rsp_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              write;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  entry_t            fifo_q [DEPTH];
  entry_t            req_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [ADDR_W-1:0] head_addr_al;
  logic [63:0]       rd_ext;
  logic              st_ovf;

  state_t            state_q;
  logic              flushed_q;
  logic [TAG_W-1:0]  op_tag_q;
  logic              op_sgn_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [1:0]        mem_datasize_q;
  logic [63:0]       mem_writedata_q;
  logic              rsp_valid_q, rsp_ovf_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [63:0]       rsp_data_q;

  // Ready depends only on occupancy, reset and flush, never on a same-cycle pop.
  assign req_ready = reset_n && !flush && (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && !flush;
  assign req_entry = {req_tag, req_write, req_size, req_signed, req_addr, req_wdata};
  assign head      = fifo_q[rd_ptr_q];

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_datasize  = mem_datasize_q;
  assign mem_writedata = mem_writedata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_ovf       = rsp_ovf_q;

  // Next-state for occupancy and pointers; flush wins over push/pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Natural alignment of the head address for its access size.
  always_comb begin
    head_addr_al = head.addr;
    case (head.size)
      2'd1:    head_addr_al[0]   = 1'b0;
      2'd2:    head_addr_al[1:0] = '0;
      2'd3:    head_addr_al[2:0] = '0;
      default: ;
    endcase
  end

  // Load extension and signed-store overflow for the operation in flight.
  always_comb begin
    rd_ext = mem_readdata;
    st_ovf = 1'b0;
    case (mem_datasize_q)
      2'd0: begin
        rd_ext = {{56{op_sgn_q & mem_readdata[7]}}, mem_readdata[7:0]};
        st_ovf = !((&mem_writedata_q[63:7]) || !(|mem_writedata_q[63:7]));
      end
      2'd1: begin
        rd_ext = {{48{op_sgn_q & mem_readdata[15]}}, mem_readdata[15:0]};
        st_ovf = !((&mem_writedata_q[63:15]) || !(|mem_writedata_q[63:15]));
      end
      2'd2: begin
        rd_ext = {{32{op_sgn_q & mem_readdata[31]}}, mem_readdata[31:0]};
        st_ovf = !((&mem_writedata_q[63:31]) || !(|mem_writedata_q[63:31]));
      end
      default: ;
    endcase
    st_ovf = st_ovf & op_sgn_q;
  end

  // Queue storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_entry;
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Issue/response FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      flushed_q       <= 1'b0;
      op_tag_q        <= '0;
      op_sgn_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_datasize_q  <= '0;
      mem_writedata_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_tag_q       <= '0;
      rsp_data_q      <= '0;
      rsp_ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q         <= S_MEM;
            flushed_q       <= 1'b0;
            op_tag_q        <= head.tag;
            op_sgn_q        <= head.sgn;
            mem_read_q      <= !head.write;
            mem_write_q     <= head.write;
            mem_address_q   <= head_addr_al;
            mem_datasize_q  <= head.size;
            mem_writedata_q <= head.wdata;
          end
        end
        S_MEM: begin
          // A flush cannot cancel the bus cycle; remember it and drop the result.
          if (flush) flushed_q <= 1'b1;
          if (mem_done) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (flushed_q || flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_tag_q   <= op_tag_q;
              rsp_data_q  <= mem_write_q ? '0 : rd_ext;
              rsp_ovf_q   <= mem_write_q & st_ovf;
            end
          end
        end
        S_RESP: begin
          if (flush || rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmix_ldst_queue.sv
// Bench for mmix_ldst_queue: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_mmix_ldst_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [7:0]  req_tag = '0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        flush = 1'b0;
  logic        mem_read, mem_write, mem_done;
  logic [63:0] mem_address, mem_writedata, mem_readdata;
  logic [1:0]  mem_datasize;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_ovf, req_ready;
  logic [7:0]  rsp_tag;
  logic [63:0] rsp_data;

  int errors = 0;
  int checks = 0;

  bit          mem_auto = 1'b0;
  int          mem_lat = 1;
  logic [63:0] rdata_next = '0;

  mmix_ldst_queue #(.DEPTH(DEPTH), .TAG_W(8), .ADDR_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_datasize(mem_datasize), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  tag;
    bit          wr;
    logic [1:0]  size;
    bit          sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef enum {M_IDLE, M_MEM, M_RESP} mph_t;

  req_t        mq[$];
  req_t        cur;
  mph_t        ph = M_IDLE;
  bit          fl = 1'b0;
  logic [7:0]  e_tag;
  logic [63:0] e_data;
  bit          e_ovf;

  function automatic logic [63:0] ext_load(input logic [63:0] rd, input logic [1:0] size, input bit sgn);
    longint unsigned m, v;
    if (size == 2'd3) return rd;
    m = 64'd1 << (8 << size);
    v = rd % m;
    if (sgn && v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  function automatic bit store_ovf(input logic [63:0] wd, input logic [1:0] size, input bit sgn);
    longint s, lo, hi;
    if (!sgn || size == 2'd3) return 1'b0;
    s  = wd;
    lo = -(longint'(1) << ((8 << size) - 1));
    hi = -lo - 1;
    return (s < lo) || (s > hi);
  endfunction

  function automatic logic [63:0] align(input logic [63:0] a, input logic [1:0] size);
    return a - (a % (64'd1 << size));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit   acc;
    req_t r;
    if (!reset_n) begin
      mq.delete();
      ph = M_IDLE;
      fl = 1'b0;
    end else begin
      acc = req_valid && !flush && (mq.size() < DEPTH);
      case (ph)
        M_IDLE: if (!flush && mq.size() > 0) begin
          cur = mq.pop_front();
          ph  = M_MEM;
          fl  = 1'b0;
        end
        M_MEM: begin
          if (flush) fl = 1'b1;
          if (mem_done) begin
            if (fl) ph = M_IDLE;
            else begin
              ph     = M_RESP;
              e_tag  = cur.tag;
              e_data = cur.wr ? 64'd0 : ext_load(mem_readdata, cur.size, cur.sgn);
              e_ovf  = cur.wr ? store_ovf(cur.wdata, cur.size, cur.sgn) : 1'b0;
            end
          end
        end
        M_RESP: if (flush || rsp_ready) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
      if (flush) mq.delete();
      if (acc) begin
        r.tag = req_tag; r.wr = req_write; r.size = req_size; r.sgn = req_signed;
        r.addr = req_addr; r.wdata = req_wdata;
        mq.push_back(r);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    check("req_ready", {63'd0, req_ready}, {63'd0, reset_n && !flush && (mq.size() < DEPTH)});
    check("mem_read", {63'd0, mem_read}, {63'd0, reset_n && ph == M_MEM && !cur.wr});
    check("mem_write", {63'd0, mem_write}, {63'd0, reset_n && ph == M_MEM && cur.wr});
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, reset_n && ph == M_RESP});
    if (!reset_n) begin
      check("rst_mem_address", mem_address, 64'd0);
      check("rst_rsp_tag", {56'd0, rsp_tag}, 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
    end else if (ph == M_MEM) begin
      check("mem_address", mem_address, align(cur.addr, cur.size));
      check("mem_datasize", {62'd0, mem_datasize}, {62'd0, cur.size});
      check("mem_writedata", mem_writedata, cur.wdata);
    end else if (ph == M_RESP) begin
      check("rsp_tag", {56'd0, rsp_tag}, {56'd0, e_tag});
      check("rsp_data", rsp_data, e_data);
      check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e_ovf});
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    mem_done = 1'b0;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && reset_n && (mem_read || mem_write)) begin
        repeat (mem_lat) @(posedge clk);
        #1;
        mem_done = 1'b1;
        mem_readdata = rdata_next;
        @(posedge clk);
        #1 mem_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] tag, input bit wr, input logic [1:0] sz,
                      input bit sg, input logic [63:0] a, input logic [63:0] wd);
    bit ok = 1'b0;
    req_valid = 1'b1; req_tag = tag; req_write = wr; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      cyc();
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: tag %0h never accepted", tag);
    end
  endtask

  task automatic wait_strobe(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = mem_read || mem_write;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no memory strobe within bound", nm);
    end
  endtask

  task automatic wait_rsp(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no response within bound", nm);
    end
  endtask

  typedef struct packed {
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a;
    logic [63:0] rd;
    logic [63:0] ea;
    logic [63:0] ed;
  } ld_vec_t;

  typedef struct packed {
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] wd;
    logic        eo;
  } st_vec_t;

  ld_vec_t lv [5];
  st_vec_t sv [7];

  // ---------------- directed sequence ----------------
  initial begin
    lv[0] = '{2'd0, 1'b1, 64'h11, 64'h0000_0000_0000_0080, 64'h11, 64'hFFFF_FFFF_FFFF_FF80};
    lv[1] = '{2'd0, 1'b0, 64'h11, 64'h1234_5678_9ABC_DEFF, 64'h11, 64'h0000_0000_0000_00FF};
    lv[2] = '{2'd2, 1'b1, 64'h37, 64'h0000_0000_8000_0000, 64'h34, 64'hFFFF_FFFF_8000_0000};
    lv[3] = '{2'd3, 1'b1, 64'h4F, 64'h8000_0000_0000_0001, 64'h48, 64'h8000_0000_0000_0001};
    lv[4] = '{2'd1, 1'b0, 64'h55, 64'hFFFF_FFFF_FFFF_8001, 64'h54, 64'h0000_0000_0000_8001};
    sv[0] = '{2'd0, 1'b1, 64'h0000_0000_0000_0080, 1'b1};
    sv[1] = '{2'd0, 1'b0, 64'h0000_0000_0000_0080, 1'b0};
    sv[2] = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    sv[3] = '{2'd1, 1'b1, 64'h0000_0000_0000_7FFF, 1'b0};
    sv[4] = '{2'd1, 1'b1, 64'h0000_0000_0000_8000, 1'b1};
    sv[5] = '{2'd2, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1};
    sv[6] = '{2'd3, 1'b1, 64'h8000_0000_0000_0000, 1'b0};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    reset_n = 1'b1;

    // Signed wyde load, memory answers two cycles after the strobe.
    mem_auto = 1'b1; mem_lat = 2; rdata_next = 64'h8001;
    send(8'd3, 1'b0, 2'd1, 1'b1, 64'h1003, 64'd0);
    wait_strobe("ldw_strobe");
    check("ldw_address", mem_address, 64'h1002);
    wait_rsp("ldw_rsp");
    check("ldw_data", rsp_data, 64'hFFFF_FFFF_FFFF_8001);
    check("ldw_tag", {56'd0, rsp_tag}, 64'd3);
    cyc();

    mem_lat = 1;
    for (int i = 0; i < 5; i++) begin
      rdata_next = lv[i].rd;
      send(8'(16 + i), 1'b0, lv[i].sz, lv[i].sg, lv[i].a, 64'd0);
      wait_strobe("ld_strobe");
      check("ld_address", mem_address, lv[i].ea);
      wait_rsp("ld_rsp");
      check("ld_data", rsp_data, lv[i].ed);
      cyc();
    end

    for (int i = 0; i < 7; i++) begin
      rdata_next = 64'hDEAD_BEEF_DEAD_BEEF;
      send(8'(32 + i), 1'b1, sv[i].sz, sv[i].sg, 64'h100, sv[i].wd);
      wait_rsp("st_rsp");
      check("st_ovf", {63'd0, rsp_ovf}, {63'd0, sv[i].eo});
      check("st_data", rsp_data, 64'd0);
      cyc();
    end

    // Fill the queue behind a stalled memory access.
    mem_auto = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i), 1'b0, 2'd3, 1'b0, 64'(i * 8), 64'd0);
    req_valid = 1'b1; req_tag = 8'd5;
    @(negedge clk);
    check("full_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    req_valid = 1'b0;
    mem_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("order_rsp");
      check("order_tag", {56'd0, rsp_tag}, 64'(i));
      cyc();
    end

    // Flush with one access on the bus and two queued.
    mem_auto = 1'b0;
    send(8'd10, 1'b0, 2'd3, 1'b0, 64'h200, 64'd0);
    send(8'd11, 1'b0, 2'd3, 1'b0, 64'h208, 64'd0);
    send(8'd12, 1'b0, 2'd3, 1'b0, 64'h210, 64'd0);
    flush = 1'b1; req_valid = 1'b1; req_tag = 8'd13;
    @(negedge clk);
    check("flush_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_mem_read_held", {63'd0, mem_read}, 64'd1);
      cyc();
    end
    mem_readdata = 64'h5555; mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_rsp", {63'd0, rsp_valid}, 64'd0);
      check("flush_no_strobe", {63'd0, mem_read}, 64'd0);
      cyc();
    end
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    mem_auto = 1'b1; rdata_next = 64'h77;
    send(8'd20, 1'b0, 2'd0, 1'b0, 64'h300, 64'd0);
    wait_rsp("post_flush_rsp");
    check("post_flush_tag", {56'd0, rsp_tag}, 64'd20);
    check("post_flush_data", rsp_data, 64'h77);
    cyc();

    // Back-pressure on the response with a second request waiting.
    rsp_ready = 1'b0; rdata_next = 64'h1234_5678_9ABC_DEF0;
    send(8'd30, 1'b0, 2'd2, 1'b0, 64'h2007, 64'd0);
    wait_rsp("stall_rsp");
    cyc();
    send(8'd31, 1'b0, 2'd3, 1'b0, 64'h2008, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_tag", {56'd0, rsp_tag}, 64'd30);
      check("stall_data", rsp_data, 64'h9ABC_DEF0);
      check("stall_no_strobe", {63'd0, mem_read | mem_write}, 64'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    wait_rsp("second_rsp");
    check("second_tag", {56'd0, rsp_tag}, 64'd31);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("resp_flush_valid", {63'd0, rsp_valid}, 64'd0);
    cyc();
    rsp_ready = 1'b1;

    // Reset while a store is on the bus.
    mem_auto = 1'b0;
    send(8'd40, 1'b1, 2'd3, 1'b0, 64'h400, 64'hAAAA);
    wait_strobe("rst_strobe");
    cyc();
    reset_n = 1'b0;
    #1;
    check("midrst_mem_write", {63'd0, mem_write}, 64'd0);
    check("midrst_mem_address", mem_address, 64'd0);
    check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    reset_n = 1'b1;
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
      check("postrst_no_strobe", {63'd0, mem_read | mem_write}, 64'd0);
      cyc();
    end
    mem_auto = 1'b1; rdata_next = 64'h80;
    send(8'd41, 1'b0, 2'd0, 1'b1, 64'h501, 64'd0);
    wait_rsp("final_rsp");
    check("final_data", rsp_data, 64'hFFFF_FFFF_FFFF_FF80);
    cyc();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
